// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between the instruction-fetch requester and
// the data-access requester. One transaction is in flight at a time. Data wins
// arbitration by default, but fetch is forced through after MAX_DATA_STREAK
// consecutive data grants taken while a fetch was waiting. A fetch redirect
// (i_flush) lets the in-flight fetch finish on the memory side but suppresses
// its ready pulse.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   // instruction-fetch requester
   input  logic                      i_req,
   input  logic [ADDR_WIDTH-1:0]     i_addr,
   input  logic                      i_flush,
   output logic                      i_ready,
   output logic [DATA_WIDTH-1:0]     i_rdata,
   // data-access requester
   input  logic                      d_req,
   input  logic                      d_we,
   input  logic [ADDR_WIDTH-1:0]     d_addr,
   input  logic [DATA_WIDTH-1:0]     d_wdata,
   input  logic [DATA_WIDTH/8-1:0]   d_be,
   output logic                      d_ready,
   output logic [DATA_WIDTH-1:0]     d_rdata,
   // memory side
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [DATA_WIDTH/8-1:0]   mem_be,
   input  logic [DATA_WIDTH-1:0]     mem_rdata,
   input  logic                      mem_ack
);

   localparam int         BE_WIDTH     = DATA_WIDTH / 8;
   localparam logic [3:0] STREAK_LIMIT = 4'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

   state_t                  state_q;
   logic [3:0]              streak_q;
   logic                    drop_q;
   logic                    mem_req_q;
   logic                    mem_we_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [DATA_WIDTH-1:0]   mem_wdata_q;
   logic [BE_WIDTH-1:0]     mem_be_q;
   logic                    i_ready_q;
   logic                    d_ready_q;
   logic [DATA_WIDTH-1:0]   i_rdata_q;
   logic [DATA_WIDTH-1:0]   d_rdata_q;
   logic                    fetch_win;

   // Fetch wins when no data access is waiting, or data has used up its streak.
   assign fetch_win = i_req && (!d_req || (streak_q == STREAK_LIMIT));

   // Transaction sequencer: arbitration, memory handshake and ready pulses.
   // The ready pulse is registered on the ack edge so it is high exactly
   // during the RESP cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         streak_q    <= 4'd0;
         drop_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         i_ready_q <= 1'b0;
         d_ready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               drop_q <= 1'b0;
               if (fetch_win) begin
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= i_addr;
                  mem_be_q   <= '1;
                  streak_q   <= 4'd0;
                  state_q    <= I_BUSY;
               end else if (d_req) begin
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= d_we;
                  mem_addr_q  <= d_addr;
                  mem_wdata_q <= d_wdata;
                  mem_be_q    <= d_be;
                  // only data grants that keep a fetch waiting count
                  if (!i_req) begin
                     streak_q <= 4'd0;
                  end else if (streak_q != STREAK_LIMIT) begin
                     streak_q <= streak_q + 4'd1;
                  end
                  state_q <= D_BUSY;
               end else begin
                  streak_q <= 4'd0;
               end
            end
            I_BUSY: begin
               if (i_flush) begin
                  drop_q <= 1'b1;
               end
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  i_rdata_q <= mem_rdata;
                  // a flush arriving with the ack still cancels the pulse
                  i_ready_q <= !(drop_q || i_flush);
                  state_q   <= RESP;
               end
            end
            D_BUSY: begin
               if (mem_ack) begin
                  mem_req_q <= 1'b0;
                  if (!mem_we_q) begin
                     d_rdata_q <= mem_rdata;
                  end
                  d_ready_q <= 1'b1;
                  state_q   <= RESP;
               end
            end
            RESP: begin
               // the pulse for this cycle was decided on the ack edge
               drop_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign i_ready   = i_ready_q;
   assign d_ready   = d_ready_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

   localparam int MAX_STREAK = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_req = 1'b0, i_flush = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic [3:0]  d_be = '0;
   logic        i_ready, d_ready, mem_req, mem_we;
   logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   int tests_run    = 0;
   int tests_failed = 0;
   int lat_cfg      = 1;   // 0 = random latency 1..4

   logic [31:0] mem_model [logic [31:0]];

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_DATA_STREAK(MAX_STREAK)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_ready(i_ready), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_model.exists(a)) return mem_model[a];
      return {a[15:0], ~a[15:0]};
   endfunction

   // Memory: acks lat cycles after it first sees mem_req, one-cycle ack pulse.
   initial begin
      int cnt;
      logic [31:0] w;
      cnt = -1;
      forever begin
         @(posedge clk);
         #1;
         if (!rst) begin
            mem_ack = 1'b0;
            cnt = -1;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
            cnt = -1;
         end else if (mem_req) begin
            if (cnt < 0) cnt = (lat_cfg != 0) ? lat_cfg : int'($urandom_range(1, 4));
            cnt--;
            if (cnt == 0) begin
               mem_ack = 1'b1;
               if (mem_we) begin
                  w = mem_rd(mem_addr);
                  for (int b = 0; b < 4; b++)
                     if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                  mem_model[mem_addr] = w;
               end else begin
                  mem_rdata = mem_rd(mem_addr);
               end
            end
         end
      end
   end

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_req: got %0b want 0", mem_req); end
      tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
      tests_run++; if ({i_ready, d_ready} !== 2'b00) begin tests_failed++; $display("FAIL reset_ready: got %b want 00", {i_ready, d_ready}); end
      tests_run++; if (mem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      tests_run++; if (mem_wdata !== 32'h0) begin tests_failed++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
      tests_run++; if (mem_be !== 4'h0) begin tests_failed++; $display("FAIL reset_mem_be: got %h want 0", mem_be); end
      tests_run++; if ({i_rdata, d_rdata} !== 64'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h/%h want 0/0", i_rdata, d_rdata); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_fetch_only;
      lat_cfg = 1;
      mem_model[32'h10] = 32'h00500093;
      i_req = 1'b1; i_addr = 32'h10;
      @(negedge clk);
      tests_run++;
      if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h10}) begin
         tests_failed++; $display("FAIL fetch_grant: got req=%0b we=%0b be=%h addr=%h want 1/0/f/00000010", mem_req, mem_we, mem_be, mem_addr);
      end
      tests_run++; if (i_ready !== 1'b0) begin tests_failed++; $display("FAIL fetch_early_ready: got %0b want 0", i_ready); end
      @(negedge clk);
      tests_run++;
      if ({i_ready, i_rdata} !== {1'b1, 32'h00500093}) begin
         tests_failed++; $display("FAIL fetch_ready: got ready=%0b rdata=%h want 1/00500093", i_ready, i_rdata);
      end
      i_req = 1'b0;
      @(negedge clk);
      tests_run++; if (i_ready !== 1'b0) begin tests_failed++; $display("FAIL fetch_ready_width: got %0b want 0", i_ready); end
      $display("[TB] fetch 0x10 -> %h", i_rdata);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_simultaneous;
      bit seen;
      lat_cfg = 1;
      mem_model[32'h100] = 32'hDEADBEEF;
      mem_model[32'h14]  = 32'h00A00113;
      i_req = 1'b1; i_addr = 32'h14;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
      @(negedge clk);
      tests_run++;
      if ({mem_we, mem_addr} !== {1'b0, 32'h100}) begin
         tests_failed++; $display("FAIL simul_first_grant: got we=%0b addr=%h want 0/00000100", mem_we, mem_addr);
      end
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (d_ready) seen = 1;
      end
      tests_run++;
      if (!seen || d_rdata !== 32'hDEADBEEF || i_ready !== 1'b0) begin
         tests_failed++; $display("FAIL simul_load: got seen=%0b rdata=%h i_ready=%0b want 1/deadbeef/0", seen, d_rdata, i_ready);
      end
      d_req = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({mem_req, mem_addr} !== {1'b1, 32'h14}) begin
         tests_failed++; $display("FAIL simul_second_grant: got req=%0b addr=%h want 1/00000014", mem_req, mem_addr);
      end
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (i_ready) seen = 1;
      end
      tests_run++;
      if (!seen || i_rdata !== 32'h00A00113) begin
         tests_failed++; $display("FAIL simul_fetch: got seen=%0b rdata=%h want 1/00a00113", seen, i_rdata);
      end
      i_req = 1'b0;
      $display("[TB] simultaneous: load 0x100 -> deadbeef, then fetch 0x14");
      repeat (2) @(negedge clk);
   endtask

   task automatic test_store;
      bit seen;
      logic [31:0] orig;
      lat_cfg = 3;
      orig = mem_rd(32'h200);
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_be = 4'h3;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests_run++;
         if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== {1'b1, 1'b1, 32'h200, 32'h12345678, 4'h3}) begin
            tests_failed++; $display("FAIL store_hold_%0d: got req=%0b we=%0b addr=%h wdata=%h be=%h want 1/1/00000200/12345678/3",
                                     k, mem_req, mem_we, mem_addr, mem_wdata, mem_be);
         end
      end
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (d_ready) seen = 1;
      end
      tests_run++;
      if (!seen || d_rdata !== 32'hDEADBEEF) begin
         tests_failed++; $display("FAIL store_ready: got seen=%0b d_rdata=%h want 1/deadbeef", seen, d_rdata);
      end
      tests_run++;
      if (mem_rd(32'h200) !== {orig[31:16], 16'h5678}) begin
         tests_failed++; $display("FAIL store_bytes: got %h want %h", mem_rd(32'h200), {orig[31:16], 16'h5678});
      end
      d_req = 1'b0; d_we = 1'b0;
      $display("[TB] store 0x200 <- 12345678 be=3");
      repeat (2) @(negedge clk);
   endtask

   task automatic test_flush;
      bit seen;
      int pulses;
      // flush during I_BUSY, ack two cycles later
      lat_cfg = 3;
      mem_model[32'h20] = 32'h11111111;
      mem_model[32'h40] = 32'h00000013;
      i_req = 1'b1; i_addr = 32'h20;
      @(negedge clk);
      tests_run++; if (mem_addr !== 32'h20) begin tests_failed++; $display("FAIL flush_grant: got %h want 00000020", mem_addr); end
      i_flush = 1'b1; i_addr = 32'h40;
      @(negedge clk);
      i_flush = 1'b0;
      repeat (2) @(negedge clk);
      tests_run++;
      if ({i_ready, i_rdata} !== {1'b0, 32'h11111111}) begin
         tests_failed++; $display("FAIL flush_suppress: got ready=%0b rdata=%h want 0/11111111", i_ready, i_rdata);
      end
      pulses = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (i_ready) begin
            pulses++;
            tests_run++;
            if ({mem_addr, i_rdata} !== {32'h40, 32'h13}) begin
               tests_failed++; $display("FAIL flush_refetch: got addr=%h rdata=%h want 00000040/00000013", mem_addr, i_rdata);
            end
            i_req = 1'b0;
         end
      end
      tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL flush_pulse_count: got %0d want 1", pulses); end
      // flush in the same cycle as the ack
      lat_cfg = 2;
      mem_model[32'h24] = 32'h22222222;
      mem_model[32'h44] = 32'h33333333;
      i_req = 1'b1; i_addr = 32'h24;
      repeat (2) @(negedge clk);
      i_flush = 1'b1; i_addr = 32'h44;
      @(negedge clk);
      i_flush = 1'b0;
      tests_run++;
      if ({i_ready, i_rdata} !== {1'b0, 32'h22222222}) begin
         tests_failed++; $display("FAIL flush_with_ack: got ready=%0b rdata=%h want 0/22222222", i_ready, i_rdata);
      end
      seen = 0;
      for (int k = 0; k < 12 && !seen; k++) begin
         @(negedge clk);
         if (i_ready) seen = 1;
      end
      tests_run++;
      if (!seen || i_rdata !== 32'h33333333) begin
         tests_failed++; $display("FAIL flush_with_ack_refetch: got seen=%0b rdata=%h want 1/33333333", seen, i_rdata);
      end
      i_req = 1'b0;
      $display("[TB] flush: dropped fetches 0x20/0x24, refetched 0x40/0x44");
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      bit seen;
      int pulses;
      lat_cfg = 4;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_be = 4'hF;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if ({mem_req, d_ready, i_ready, mem_addr, mem_be, d_rdata, i_rdata} !== '0) begin
         tests_failed++; $display("FAIL reset_mid_outputs: got req=%0b d_ready=%0b addr=%h be=%h d_rdata=%h want all 0",
                                  mem_req, d_ready, mem_addr, mem_be, d_rdata);
      end
      d_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (d_ready || i_ready || mem_req) pulses++;
      end
      tests_run++; if (pulses != 0) begin tests_failed++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", pulses); end
      lat_cfg = 1;
      mem_model[32'h30] = 32'h44444444;
      i_req = 1'b1; i_addr = 32'h30;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (i_ready) seen = 1;
      end
      tests_run++;
      if (!seen || i_rdata !== 32'h44444444) begin
         tests_failed++; $display("FAIL reset_mid_fetch: got seen=%0b rdata=%h want 1/44444444", seen, i_rdata);
      end
      i_req = 1'b0;
      $display("[TB] reset mid-load abandoned, fetch 0x30 -> %h", i_rdata);
      repeat (2) @(negedge clk);
   endtask

   task automatic test_starvation;
      string got, want;
      bit last_req, seen;
      int grants;
      lat_cfg = 1;
      want = "DDDDIDDDDI";
      got = "";
      i_req = 1'b1; i_addr = 32'h50;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hF;
      last_req = 1'b0;
      grants = 0;
      for (int k = 0; k < 200 && grants < 10; k++) begin
         @(negedge clk);
         if (mem_req && !last_req) begin
            got = {got, (mem_addr == 32'h50) ? "I" : "D"};
            grants++;
         end
         last_req = mem_req;
      end
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (i_ready || d_ready) seen = 1;
      end
      i_req = 1'b0; d_req = 1'b0;
      tests_run++;
      if (got != want || !seen) begin
         tests_failed++; $display("FAIL starvation_order: got %s (last done=%0b) want %s", got, seen, want);
      end
      $display("[TB] starvation grant order %s", got);
      repeat (3) @(negedge clk);
   endtask

   // Randomized traffic; each grant is checked against the arbitration rule
   // and each ready against the owner and data of the outstanding grant.
   task automatic test_random;
      int done, streak_m, igap, dgap;
      bit last_req, pend_valid, pend_fetch, exp_fetch, finished;
      logic [31:0] pend_data, exp_d, rdata;
      lat_cfg = 0;
      exp_d = mem_rd(32'h300);
      streak_m = 0; done = 0; igap = 0; dgap = 1;
      last_req = 1'b0; pend_valid = 1'b0; pend_fetch = 1'b0; pend_data = '0;
      finished = 1'b0;
      for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
         @(negedge clk);
         if (mem_req && !last_req) begin
            exp_fetch = i_req && (!d_req || streak_m == MAX_STREAK);
            tests_run++;
            if (!i_req && !d_req) begin
               tests_failed++; $display("FAIL rand_spurious_grant: got grant addr=%h want no grant", mem_addr);
            end else if (exp_fetch) begin
               if ({mem_we, mem_be, mem_addr} !== {1'b0, 4'hF, i_addr}) begin
                  tests_failed++; $display("FAIL rand_grant_fetch: got we=%0b be=%h addr=%h want 0/f/%h", mem_we, mem_be, mem_addr, i_addr);
               end
               pend_fetch = 1'b1;
               pend_data = mem_rd(i_addr);
               streak_m = 0;
            end else begin
               if ({mem_we, mem_be, mem_addr} !== {d_we, d_be, d_addr}) begin
                  tests_failed++; $display("FAIL rand_grant_data: got we=%0b be=%h addr=%h want %0b/%h/%h", mem_we, mem_be, mem_addr, d_we, d_be, d_addr);
               end
               if (d_we) begin
                  tests_run++;
                  if (mem_wdata !== d_wdata) begin
                     tests_failed++; $display("FAIL rand_wdata: got %h want %h", mem_wdata, d_wdata);
                  end
               end
               pend_fetch = 1'b0;
               if (!d_we) exp_d = mem_rd(d_addr);
               pend_data = exp_d;
               streak_m = i_req ? streak_m + 1 : 0;
            end
            pend_valid = 1'b1;
         end
         last_req = mem_req;

         if (i_ready || d_ready) begin
            tests_run++;
            rdata = i_ready ? i_rdata : d_rdata;
            if (i_ready && d_ready) begin
               tests_failed++; $display("FAIL rand_both_ready: got i_ready=1 d_ready=1 want one");
            end else if (!pend_valid) begin
               tests_failed++; $display("FAIL rand_ready_no_grant: got ready=%0b%0b want 00", i_ready, d_ready);
            end else if (i_ready != pend_fetch) begin
               tests_failed++; $display("FAIL rand_owner: got i_ready=%0b want %0b", i_ready, pend_fetch);
            end else if (rdata !== pend_data) begin
               tests_failed++; $display("FAIL rand_rdata: got %h want %h", rdata, pend_data);
            end
            $display("[TB] rand txn %0d %s addr=%h data=%h", done, i_ready ? "fetch" : (d_we ? "store" : "load"),
                     i_ready ? i_addr : d_addr, rdata);
            pend_valid = 1'b0;
            done++;
            if (i_ready) begin i_req = 1'b0; igap = $urandom_range(0, 2); end
            if (d_ready) begin d_req = 1'b0; dgap = $urandom_range(0, 2); end
         end

         if (!i_req && done < 80) begin
            if (igap == 0) begin
               i_req = 1'b1;
               i_addr = 32'($urandom_range(0, 255)) << 2;
            end else igap--;
         end
         if (!d_req && done < 80) begin
            if (dgap == 0) begin
               d_req = 1'b1;
               d_we = 1'($urandom_range(0, 1));
               d_addr = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
               d_wdata = $urandom;
               d_be = 4'($urandom_range(1, 15));
            end else dgap--;
         end
         if (done >= 80 && !i_req && !d_req && !pend_valid) finished = 1'b1;
      end
      tests_run++;
      if (!finished) begin
         tests_failed++; $display("FAIL rand_timeout: got %0d transactions want 80 within budget", done);
      end
   endtask

   initial begin
      test_reset();
      test_fetch_only();
      test_simultaneous();
      test_store();
      test_flush();
      test_reset_mid();
      test_starvation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
